soc_axi_err_slv: RTL and testbench

AXI4 responder that terminates every transaction the SoC crossbar cannot decode, i.e. any address outside the peripheral map. It accepts write bursts, drains their data, and answers DECERR. It returns full-length read bursts with DECERR and a fixed data pattern. It also keeps an error counter and a last-bad-address capture for debug. It sits on the crossbar's default (no-match) master port, with slave-side ID width.

---
 rtl/soc_axi_err_slv_pkg.sv | 20 ++
 rtl/soc_axi_err_slv_rd.sv | 60 ++++++
 rtl/soc_axi_err_slv.sv | 101 ++++++++++
 tb/tb_soc_axi_err_slv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_axi_err_slv_pkg.sv
// soc_axi_err_slv_pkg: shared SoC definitions for the default AXI error responder
package soc_axi_err_slv_pkg;

    localparam logic [1:0] RespOkay = 2'b00;
    localparam logic [1:0] RespDecErr = 2'b11;

    localparam logic [63:0] ErrDataDefault = 64'hBADC_AB1E_BADC_AB1E;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DRAIN,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

endpackage

// File: rtl/soc_axi_err_slv_rd.sv
// soc_axi_err_slv_rd: read path returning full-length DECERR bursts of fixed data
module soc_axi_err_slv_rd
    import soc_axi_err_slv_pkg::*;
#(
    parameter int unsigned IdWidth = 7,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] ErrData = ErrDataDefault
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o
);

    r_state_e   r_state, r_state_nxt;
    logic [7:0] beat_cnt;

    assign ar_ready_o = r_state == R_IDLE;
    assign r_valid_o  = r_state == R_BURST;
    assign r_last_o   = r_valid_o && beat_cnt == 8'd0;
    assign r_resp_o   = r_valid_o ? RespDecErr : RespOkay;
    assign r_data_o   = ErrData;

    // Read-path state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= R_IDLE;
        else         r_state <= r_state_nxt;
    end

    // Read-path next state: leave the burst only on the accepted last beat
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_valid_i) r_state_nxt = R_BURST;
            R_BURST: if (r_ready_i && r_last_o) r_state_nxt = R_IDLE;
        endcase
    end

    // Capture the AR ID and count the remaining beats down to the last one
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_o   <= '0;
            beat_cnt <= '0;
        end else if (ar_valid_i && ar_ready_o) begin
            r_id_o   <= ar_id_i;
            beat_cnt <= ar_len_i;
        end else if (r_valid_o && r_ready_i && !r_last_o) begin
            beat_cnt <= beat_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/soc_axi_err_slv.sv
// soc_axi_err_slv: crossbar default slave answering every undecoded request with DECERR
module soc_axi_err_slv
    import soc_axi_err_slv_pkg::*;
#(
    parameter int unsigned AxiIdWidth = 7,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter logic [AxiDataWidth-1:0] ErrData = ErrDataDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [AxiIdWidth-1:0]   aw_id_i,
    input  logic [AxiAddrWidth-1:0] aw_addr_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic                    w_last_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [AxiIdWidth-1:0]   b_id_o,
    output logic [1:0]              b_resp_o,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [AxiIdWidth-1:0]   ar_id_i,
    input  logic [AxiAddrWidth-1:0] ar_addr_i,
    input  logic [7:0]              ar_len_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [AxiIdWidth-1:0]   r_id_o,
    output logic [AxiDataWidth-1:0] r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o,
    output logic [31:0]             err_cnt_o,
    output logic [AxiAddrWidth-1:0] err_addr_o
);

    w_state_e    w_state, w_state_nxt;
    logic        aw_hs, ar_hs;
    logic [32:0] cnt_sum;

    assign aw_ready_o = w_state == W_IDLE;
    assign w_ready_o  = w_state == W_DRAIN;
    assign b_valid_o  = w_state == W_RESP;
    assign b_resp_o   = b_valid_o ? RespDecErr : RespOkay;
    assign aw_hs      = aw_valid_i && aw_ready_o;
    assign ar_hs      = ar_valid_i && ar_ready_o;
    assign cnt_sum    = 33'(err_cnt_o) + 33'(aw_hs) + 33'(ar_hs);

    // Write-path state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) w_state <= W_IDLE;
        else         w_state <= w_state_nxt;
    end

    // Write-path next state: accept AW, swallow data up to WLAST, then answer
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_valid_i) w_state_nxt = W_DRAIN;
            W_DRAIN: if (w_valid_i && w_last_i) w_state_nxt = W_RESP;
            W_RESP:  if (b_ready_i) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Hold the B ID, count bad requests (saturating) and keep the latest bad address, AR winning ties
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_id_o     <= '0;
            err_cnt_o  <= '0;
            err_addr_o <= '0;
        end else begin
            if (aw_hs) b_id_o <= aw_id_i;
            if (aw_hs || ar_hs) begin
                err_cnt_o  <= cnt_sum[32] ? '1 : cnt_sum[31:0];
                err_addr_o <= ar_hs ? ar_addr_i : aw_addr_i;
            end
        end
    end

    soc_axi_err_slv_rd #(
        .IdWidth  (AxiIdWidth),
        .DataWidth(AxiDataWidth),
        .ErrData  (ErrData)
    ) u_rd (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .ar_valid_i(ar_valid_i),
        .ar_ready_o(ar_ready_o),
        .ar_id_i   (ar_id_i),
        .ar_len_i  (ar_len_i),
        .r_valid_o (r_valid_o),
        .r_ready_i (r_ready_i),
        .r_id_o    (r_id_o),
        .r_data_o  (r_data_o),
        .r_resp_o  (r_resp_o),
        .r_last_o  (r_last_o)
    );

endmodule

// File: tb/tb_soc_axi_err_slv.sv
// tb_soc_axi_err_slv: directed scoreboard bench for the default AXI error responder
module tb_soc_axi_err_slv;

    localparam logic [63:0] ExpData = 64'hBADC_AB1E_BADC_AB1E;

    typedef struct packed {
        logic [6:0] id;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, aw_ready;
    logic [6:0]  aw_id = '0;
    logic [63:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic        b_valid, b_ready = 1'b0;
    logic [6:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [6:0]  ar_id = '0;
    logic [63:0] ar_addr = '0;
    logic [7:0]  ar_len = '0;
    logic        r_valid, r_ready = 1'b0, r_last;
    logic [6:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [31:0] err_cnt;
    logic [63:0] err_addr;

    int n_cmp = 0;
    int n_bad = 0;
    beat_t      rq[$];
    logic [6:0] bq[$];

    always #5 clk = ~clk;

    soc_axi_err_slv dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .err_cnt_o(err_cnt), .err_addr_o(err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [6:0] id, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) rq.push_back('{id: id, last: (i == int'(len))});
    endtask

    task automatic issue_ar(input logic [6:0] id, input logic [63:0] addr, input logic [7:0] len);
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
        push_read(id, len);
    endtask

    // R monitor: scoreboard pop on each accepted beat, stability check on stalls
    logic       r_stall = 1'b0;
    logic [6:0] r_id_prev;
    logic       r_last_prev;
    always @(negedge clk) begin : mon_r
        beat_t e;
        if (rst_n && r_valid) begin
            if (r_stall) begin
                chk("r_id_stable", r_id, r_id_prev);
                chk("r_last_stable", r_last, r_last_prev);
            end
            if (r_ready) begin
                if (rq.size() == 0) chk("r_unexpected_beat", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("r_id", r_id, e.id);
                    chk("r_last", r_last, e.last);
                    chk("r_data", r_data, ExpData);
                    chk("r_resp", r_resp, 2'b11);
                end
            end
        end
        r_stall = rst_n && r_valid && !r_ready;
        r_id_prev = r_id;
        r_last_prev = r_last;
    end

    // B monitor: scoreboard pop on each accepted response
    always @(negedge clk) begin : mon_b
        if (rst_n && b_valid && b_ready) begin
            if (bq.size() == 0) chk("b_unexpected", 1, 0);
            else begin
                chk("b_id", b_id, bq.pop_front());
                chk("b_resp", b_resp, 2'b11);
            end
        end
    end

    initial begin
        // reset state
        #12;
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_last", r_last, 0);
        chk("rst_b_id", b_id, 0);
        chk("rst_r_id", r_id, 0);
        chk("rst_b_resp", b_resp, 0);
        chk("rst_r_resp", r_resp, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_addr", err_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single write
        aw_valid = 1'b1; aw_id = 7'd5; aw_addr = 64'h1_0000_0000;
        tick();
        aw_valid = 1'b0;
        chk("wr_w_ready", w_ready, 1);
        chk("wr_aw_busy", aw_ready, 0);
        chk("wr_cnt", err_cnt, 1);
        chk("wr_addr", err_addr, 64'h1_0000_0000);
        w_valid = 1'b1; w_last = 1'b1; bq.push_back(7'd5);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        chk("wr_b_valid", b_valid, 1);
        chk("wr_w_ready_off", w_ready, 0);
        tick();
        chk("wr_b_held", b_valid, 1);
        chk("wr_b_id_held", b_id, 5);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("wr_b_done", bq.size(), 0);
        chk("wr_aw_ready_back", aw_ready, 1);

        // 4-beat read, no backpressure
        r_ready = 1'b1;
        issue_ar(7'h42, 64'h2000_0000_0000, 8'd3);
        tick();
        ar_valid = 1'b0;
        chk("rd4_r_valid", r_valid, 1);
        chk("rd4_ar_busy", ar_ready, 0);
        chk("rd4_cnt", err_cnt, 2);
        chk("rd4_addr", err_addr, 64'h2000_0000_0000);
        repeat (3) tick();
        chk("rd4_last_beat", r_last, 1);
        tick();
        chk("rd4_done", rq.size(), 0);
        chk("rd4_ar_ready_back", ar_ready, 1);
        chk("rd4_r_valid_off", r_valid, 0);
        r_ready = 1'b0;

        // 256-beat read with random backpressure
        issue_ar(7'h13, 64'h3000, 8'd255);
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i < 3000 && rq.size() != 0; i++) begin
            r_ready = 1'($urandom_range(0, 1));
            tick();
        end
        r_ready = 1'b0;
        chk("rd256_done", rq.size(), 0);
        chk("rd256_ar_ready", ar_ready, 1);
        chk("rd256_cnt", err_cnt, 3);

        // simultaneous AW and AR
        aw_valid = 1'b1; aw_id = 7'd3; aw_addr = 64'hA0;
        issue_ar(7'd4, 64'hB0, 8'd1);
        bq.push_back(7'd3);
        tick();
        aw_valid = 1'b0; ar_valid = 1'b0;
        chk("dual_cnt", err_cnt, 5);
        chk("dual_addr", err_addr, 64'hB0);
        w_valid = 1'b1; w_last = 1'b1; r_ready = 1'b1; b_ready = 1'b1;
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        for (int i = 0; i < 20 && (rq.size() != 0 || bq.size() != 0); i++) tick();
        r_ready = 1'b0; b_ready = 1'b0;
        chk("dual_r_done", rq.size(), 0);
        chk("dual_b_done", bq.size(), 0);
        chk("dual_idle", {aw_ready, ar_ready}, 2'b11);

        // W ahead of AW is stalled
        w_valid = 1'b1; w_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("early_w_stalled", w_ready, 0);
        end
        aw_valid = 1'b1; aw_id = 7'd9; aw_addr = 64'h1234; bq.push_back(7'd9);
        tick();
        aw_valid = 1'b0;
        chk("early_w_ready", w_ready, 1);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        chk("early_b_valid", b_valid, 1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("early_b_done", bq.size(), 0);
        chk("early_cnt", err_cnt, 6);
        chk("early_addr", err_addr, 64'h1234);

        // reset during beat 2 of an 8-beat read
        r_ready = 1'b1;
        issue_ar(7'h11, 64'hC0, 8'd7);
        tick();
        ar_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_ar_ready", ar_ready, 1);
        chk("mid_rst_cnt", err_cnt, 0);
        chk("mid_rst_addr", err_addr, 0);
        rq.delete();
        @(negedge clk);
        chk("mid_rst_r_valid_hold", r_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        issue_ar(7'h22, 64'hD0, 8'd2);
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i < 20 && rq.size() != 0; i++) tick();
        r_ready = 1'b0;
        chk("post_rst_done", rq.size(), 0);
        chk("post_rst_cnt", err_cnt, 1);
        chk("post_rst_addr", err_addr, 64'hD0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
